cordic_arbiter: RTL and testbench

//  Shares one cordicdpath instance between N_REQ requesters. Arbitrates round-robin,

---
 rtl/cordic_arbiter.sv | 146 ++++++++++++++
 tb/tb_cordic_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin sharing of one cordicdpath between N_REQ requesters
// Grants one requester at a time, starts the datapath, waits for its finish or a watchdog abort.
module cordic_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 16,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] theta_in,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [W-1:0]       result,
   output logic               err,
   output logic [W-1:0]       dp_theta,
   output logic               dp_bgn,
   input  logic               dp_fin,
   input  logic [W-1:0]       dp_cos
);

   localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int WDW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      winner_q, winner_d;
   logic [WDW-1:0]     wd_q, wd_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [W-1:0]       result_q, result_d;
   logic               err_q, err_d;
   logic [W-1:0]       dp_theta_q, dp_theta_d;
   logic               dp_bgn_q, dp_bgn_d;

   logic               win_found;
   logic [IW-1:0]      win_idx;

   // First asserted request scanning upward from rr_ptr, wrapping at N_REQ.
   function automatic logic [IW:0] pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] ptr);
      logic [IW:0] res;
      int          j;
      res = '0;
      for (int i = 0; i < N_REQ; i++) begin
         j = (int'(ptr) + i) % N_REQ;
         if (!res[IW] && r[j]) begin
            res = {1'b1, IW'(j)};
         end
      end
      return res;
   endfunction

   always_comb begin
      {win_found, win_idx} = pick(req, rr_ptr_q);
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      winner_d   = winner_q;
      wd_d       = wd_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      result_d   = result_q;
      err_d      = err_q;
      dp_theta_d = dp_theta_q;
      dp_bgn_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               winner_d   = win_idx;
               dp_theta_d = theta_in[int'(win_idx)*W +: W];
               gnt_d      = N_REQ'(1) << win_idx;
               dp_bgn_d   = 1'b1;
               state_d    = S_START;
            end
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            wd_d = wd_q + WDW'(1);
            // A finish arriving on the abort cycle still counts as a good result.
            if (dp_fin) begin
               result_d = dp_cos;
               err_d    = 1'b0;
               done_d   = N_REQ'(1) << winner_q;
               state_d  = S_DONE;
            end else if (wd_q == WDW'(TIMEOUT - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               done_d   = N_REQ'(1) << winner_q;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            gnt_d    = '0;
            rr_ptr_d = (int'(winner_q) == N_REQ - 1) ? '0 : winner_q + IW'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         winner_q   <= '0;
         wd_q       <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         dp_theta_q <= '0;
         dp_bgn_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         winner_q   <= winner_d;
         wd_q       <= wd_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         result_q   <= result_d;
         err_q      <= err_d;
         dp_theta_q <= dp_theta_d;
         dp_bgn_q   <= dp_bgn_d;
      end
   end

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign result   = result_q;
   assign err      = err_q;
   assign dp_theta = dp_theta_q;
   assign dp_bgn   = dp_bgn_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - self-checking bench for cordic_arbiter
// A stub datapath answers dp_bgn after a chosen delay; a round-robin model predicts each grant.
module tb_cordic_arbiter;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int TMO = 32;

   logic           clk;
   logic           rst_b;
   logic [N-1:0]   req;
   logic [N*W-1:0] theta_in;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [W-1:0]   result;
   logic           err;
   logic [W-1:0]   dp_theta;
   logic           dp_bgn;
   logic           dp_fin;
   logic [W-1:0]   dp_cos;

   int             checks;
   int             failures;
   int             cyc;
   int             m_rr;
   int             stub_delay;
   int             fin_at;
   int             spur_at;
   bit             stub_armed;
   logic [W-1:0]   last_cos;
   logic [W-1:0]   theta_arr [N];

   cordic_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_b(rst_b), .req(req), .theta_in(theta_in), .gnt(gnt), .done(done),
      .result(result), .err(err), .dp_theta(dp_theta), .dp_bgn(dp_bgn), .dp_fin(dp_fin),
      .dp_cos(dp_cos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath stub: finishes stub_delay cycles after the START cycle it observes.
   initial begin
      dp_fin = 1'b0; dp_cos = '0; stub_armed = 0; fin_at = -1; last_cos = '0;
      forever begin
         @(negedge clk);
         dp_fin = 1'b0;
         if (rst_b !== 1'b1) begin
            stub_armed = 0;
         end else begin
            if (stub_armed && cyc == fin_at) begin
               dp_fin = 1'b1; dp_cos = W'($urandom); last_cos = dp_cos; stub_armed = 0;
            end else if (cyc == spur_at) begin
               dp_fin = 1'b1; dp_cos = W'($urandom);
            end
            if (dp_bgn === 1'b1 && stub_delay >= 0) begin
               stub_armed = 1; fin_at = cyc + stub_delay;
            end
         end
      end
   end

   function automatic int model_pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++) begin
         if (r[(m_rr + i) % N]) return (m_rr + i) % N;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_thetas();
      for (int i = 0; i < N; i++) theta_arr[i] = W'($urandom);
      theta_in = {theta_arr[3], theta_arr[2], theta_arr[1], theta_arr[0]};
   endtask

   // Follows one operation from dp_bgn to its done pulse, returning what was observed.
   task automatic wait_op(input int budget, output int widx, output int didx, output logic [W-1:0] th,
                          output int t_bgn, output int t_done, output logic [W-1:0] res,
                          output logic er, output bit expired, output int bad);
      widx = -1; didx = -1; th = '0; t_bgn = -1; t_done = -1; res = '0; er = 1'b0;
      expired = 1; bad = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (dp_bgn === 1'b1) begin
            if (t_bgn >= 0) bad++;
            t_bgn = cyc; th = dp_theta; widx = onehot_idx(gnt);
            if ($countones(gnt) != 1) bad++;
         end else if (t_bgn >= 0 && dp_theta !== th) begin
            bad++;
         end
         if ($countones(gnt) > 1) bad++;
         if (done !== '0) begin
            t_done = cyc; res = result; er = err; didx = onehot_idx(done);
            if ($countones(done) != 1) bad++;
            expired = 0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_b = 1'b0; req = '0; theta_in = '0; stub_delay = -1; spur_at = -1;
      repeat (3) @(negedge clk);
      checks++; if ({gnt, done, dp_bgn} !== '0) begin failures++;
         $display("FAIL reset_ctl got gnt=%b done=%b bgn=%b want 0", gnt, done, dp_bgn); end
      checks++; if ({result, err} !== '0) begin failures++;
         $display("FAIL reset_res got result=%h err=%b want 0", result, err); end
      checks++; if (dp_theta !== '0) begin failures++;
         $display("FAIL reset_theta got %h want 0", dp_theta); end
      rst_b = 1'b1; m_rr = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int widx, didx, tb_, td, bad, c0; logic [W-1:0] th, res; logic er; bit ex;
      set_thetas();
      theta_arr[0] = 16'h31EB;
      theta_in = {theta_arr[3], theta_arr[2], theta_arr[1], theta_arr[0]};
      stub_delay = 7; c0 = cyc; req = 4'b0001;
      wait_op(60, widx, didx, th, tb_, td, res, er, ex, bad);
      req = '0;
      checks++; if (ex || widx != 0 || didx != 0) begin failures++;
         $display("FAIL single_winner got gnt_idx=%0d done_idx=%0d expired=%0d want 0", widx, didx, ex); end
      checks++; if (th !== 16'h31EB) begin failures++;
         $display("FAIL single_theta got %h want 31eb", th); end
      checks++; if (tb_ != c0 + 1 || td != tb_ + 8) begin failures++;
         $display("FAIL single_latency got bgn=%0d done=%0d want %0d %0d", tb_, td, c0 + 1, c0 + 9); end
      checks++; if (res !== last_cos || er !== 1'b0 || bad != 0) begin failures++;
         $display("FAIL single_result got %h err=%b bad=%0d want %h err=0", res, er, bad, last_cos); end
      @(negedge clk);
      checks++; if (done !== '0) begin failures++;
         $display("FAIL single_done_width got done=%b want 0", done); end
      m_rr = 1;
   endtask

   task automatic run_held(input string name, input logic [N-1:0] rv, input int n_ops, input bit rnd_delay);
      int widx, didx, tb_, td, bad, exp, prev_td, d; logic [W-1:0] th, res; logic er; bit ex;
      set_thetas(); prev_td = -1; req = rv;
      for (int k = 0; k < n_ops; k++) begin
         d = rnd_delay ? $urandom_range(1, 12) : 5;
         stub_delay = d; exp = model_pick(rv);
         wait_op(80, widx, didx, th, tb_, td, res, er, ex, bad);
         if (k == n_ops - 1) req = '0;
         checks++; if (ex || widx != exp || didx != exp) begin failures++;
            $display("FAIL %s_order op%0d got gnt=%0d done=%0d want %0d", name, k, widx, didx, exp); end
         checks++; if (exp >= 0 && th !== theta_arr[exp]) begin failures++;
            $display("FAIL %s_theta op%0d got %h want %h", name, k, th, theta_arr[exp]); end
         checks++; if (td != tb_ + d + 1 || (prev_td >= 0 && tb_ != prev_td + 2) || bad != 0) begin
            failures++;
            $display("FAIL %s_timing op%0d got bgn=%0d done=%0d bad=%0d prev_done=%0d delay=%0d",
                     name, k, tb_, td, bad, prev_td, d); end
         checks++; if (res !== last_cos || er !== 1'b0) begin failures++;
            $display("FAIL %s_result op%0d got %h err=%b want %h err=0", name, k, res, er, last_cos); end
         prev_td = td;
         if (exp >= 0) m_rr = (exp + 1) % N;
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int widx, didx, tb_, td, bad, exp; logic [W-1:0] th, res; logic er; bit ex;
      set_thetas(); stub_delay = -1; req = 4'b1000; exp = model_pick(req);
      wait_op(80, widx, didx, th, tb_, td, res, er, ex, bad);
      req = 4'b0110;
      checks++; if (ex || widx != exp || td != tb_ + TMO + 1) begin failures++;
         $display("FAIL timeout_latency got idx=%0d bgn=%0d done=%0d want idx=%0d done=bgn+%0d",
                  widx, tb_, td, exp, TMO + 1); end
      checks++; if (er !== 1'b1 || res !== '0) begin failures++;
         $display("FAIL timeout_flags got err=%b result=%h want err=1 result=0", er, res); end
      m_rr = (exp + 1) % N;
      stub_delay = 3; exp = model_pick(req);
      wait_op(40, widx, didx, th, tb_, td, res, er, ex, bad);
      req = '0;
      checks++; if (ex || widx != exp || er !== 1'b0 || res !== last_cos || td != tb_ + 4) begin
         failures++;
         $display("FAIL timeout_recover got idx=%0d err=%b res=%h want idx=%0d err=0 res=%h",
                  widx, er, res, exp, last_cos); end
      m_rr = (exp + 1) % N;
      @(negedge clk);
   endtask

   task automatic test_fin_edge();
      int widx, didx, tb_, td, bad, exp; logic [W-1:0] th, res, held; logic er; bit ex;
      held = last_cos;
      spur_at = cyc + 1;
      repeat (4) @(negedge clk);
      spur_at = -1;
      checks++; if (done !== '0 || gnt !== '0 || dp_bgn !== 1'b0 || result !== held || err !== 1'b0) begin
         failures++;
         $display("FAIL idle_fin got done=%b gnt=%b bgn=%b result=%h err=%b want idle result=%h",
                  done, gnt, dp_bgn, result, err, held); end
      set_thetas(); stub_delay = TMO; req = 4'b0001; exp = model_pick(req);
      wait_op(80, widx, didx, th, tb_, td, res, er, ex, bad);
      req = '0;
      checks++; if (ex || widx != exp || td != tb_ + TMO + 1 || er !== 1'b0 || res !== last_cos) begin
         failures++;
         $display("FAIL coincident_fin got done=%0d err=%b res=%h want done=%0d err=0 res=%h",
                  td, er, res, tb_ + TMO + 1, last_cos); end
      m_rr = (exp + 1) % N;
      @(negedge clk);
   endtask

   task automatic test_random();
      int widx, didx, tb_, td, bad, exp, d; logic [W-1:0] th, res, exp_res; logic er, exp_er; bit ex;
      req = N'($urandom_range(1, 15));
      for (int k = 0; k < 20; k++) begin
         set_thetas();
         d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, TMO);
         stub_delay = d; exp = model_pick(req);
         wait_op(80, widx, didx, th, tb_, td, res, er, ex, bad);
         req = N'($urandom_range(1, 15));
         exp_res = (d < 0) ? '0 : last_cos; exp_er = (d < 0);
         checks++; if (ex || widx != exp || didx != exp || th !== theta_arr[exp] || bad != 0) begin
            failures++;
            $display("FAIL random_grant op%0d got idx=%0d/%0d theta=%h bad=%0d want idx=%0d theta=%h",
                     k, widx, didx, th, bad, exp, theta_arr[exp]); end
         checks++; if (td != tb_ + ((d < 0) ? TMO : d) + 1 || res !== exp_res || er !== exp_er) begin
            failures++;
            $display("FAIL random_result op%0d got done=%0d res=%h err=%b want done=%0d res=%h err=%b",
                     k, td, res, er, tb_ + ((d < 0) ? TMO : d) + 1, exp_res, exp_er); end
         m_rr = (exp + 1) % N;
      end
      req = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_midop();
      int widx, didx, tb_, td, bad, exp, seen; logic [W-1:0] th, res; logic er; bit ex;
      stub_delay = -1; req = 4'b0100; seen = 0;
      for (int k = 0; k < 10 && seen == 0; k++) begin
         @(negedge clk);
         if (dp_bgn === 1'b1) seen = 1;
      end
      checks++; if (seen == 0) begin failures++;
         $display("FAIL midop_start got no dp_bgn within 10 cycles want one"); end
      repeat (3) @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      checks++; if ({gnt, done, dp_bgn, result, err, dp_theta} !== '0) begin failures++;
         $display("FAIL midop_async got gnt=%b done=%b bgn=%b res=%h err=%b theta=%h want all 0",
                  gnt, done, dp_bgn, result, err, dp_theta); end
      req = '0; seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done !== '0) seen = 1;
      end
      rst_b = 1'b1; m_rr = 0;
      checks++; if (seen != 0) begin failures++;
         $display("FAIL midop_no_done got a done pulse during reset want none"); end
      set_thetas(); stub_delay = 4; req = 4'b1111; exp = model_pick(req);
      wait_op(40, widx, didx, th, tb_, td, res, er, ex, bad);
      req = '0;
      checks++; if (ex || widx != 0 || exp != 0 || th !== theta_arr[0] || res !== last_cos || er !== 1'b0) begin
         failures++;
         $display("FAIL midop_fresh got idx=%0d theta=%h res=%h err=%b want idx=0 theta=%h res=%h",
                  widx, th, res, er, theta_arr[0], last_cos); end
      @(negedge clk);
   endtask

   initial begin
      checks = 0; failures = 0; m_rr = 0; stub_delay = -1; spur_at = -1;
      rst_b = 1'b0; req = '0; theta_in = '0;
      test_reset();
      test_single();
      run_held("all_four", 4'b1111, 5, 1'b0);
      run_held("no_starve", 4'b0101, 4, 1'b1);
      test_timeout();
      test_fin_edge();
      test_random();
      run_held("pair", 4'b0010, 1, 1'b0);
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
